// File: rtl/traffic_intersection_ctrl_if.sv
// Signal bundle between the intersection controller and whatever samples its lamps.
//   emergency    : emergency-vehicle request into the controller
//   out_ns       : NS lamps {left, green, yellow, red}
//   out_ew       : EW lamps, same encoding
//   phase        : current phase code (debug / verification)
//   emerg_active : high while the preemption clearance or all-stop is running
// master = controller side, slave = lamp driver / observer side.
interface traffic_intersection_ctrl_if;
   logic       emergency;
   logic [3:0] out_ns;
   logic [3:0] out_ew;
   logic [3:0] phase;
   logic       emerg_active;

   modport master (input emergency, output out_ns, output out_ew, output phase, output emerg_active);
   modport slave  (output emergency, input out_ns, input out_ew, input phase, input emerg_active);
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller with emergency preemption.
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset
//   sig     : traffic_intersection_ctrl_if.master (emergency in; lamps, phase, emerg_active out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// NS_LEFT  | NS protected left turn, EW red
// NS_GREEN | NS green, EW red
// NS_YEL   | NS yellow, EW red
// AR1      | all-red clearance before EW
// EW_LEFT  | EW protected left turn, NS red
// EW_GREEN | EW green, NS red
// EW_YEL   | EW yellow, NS red
// AR2      | all-red clearance before NS
// PRE_CLR  | preemption: interrupted approach yellow for T_YEL cycles
// ALLSTOP  | preemption: all red, held for EMERG_MIN and while emergency
module traffic_intersection_ctrl #(
   parameter int CW         = 5,
   parameter int T_LEFT_NS  = 5,
   parameter int T_GREEN_NS = 10,
   parameter int T_LEFT_EW  = 5,
   parameter int T_GREEN_EW = 10,
   parameter int T_YEL      = 3,
   parameter int T_ALLRED   = 2,
   parameter int EMERG_MIN  = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   traffic_intersection_ctrl_if.master  sig
);

   typedef enum logic [3:0] {
      NS_LEFT  = 4'd0,
      NS_GREEN = 4'd1,
      NS_YEL   = 4'd2,
      AR1      = 4'd3,
      EW_LEFT  = 4'd4,
      EW_GREEN = 4'd5,
      EW_YEL   = 4'd6,
      AR2      = 4'd7,
      PRE_CLR  = 4'd8,
      ALLSTOP  = 4'd9
   } phase_e;

   phase_e          phase_q, phase_d, saved_phase_q, saved_phase_d, norm_phase;
   logic [CW-1:0]   cnt_q, cnt_d, hold_q, hold_d, saved_cnt_q, saved_cnt_d, norm_cnt;
   logic            clr_ew_q, clr_ew_d;   // 1: PRE_CLR yellow is on the EW approach

   function automatic logic [CW-1:0] last_cnt(input phase_e ph);
      case (ph)
         NS_LEFT:         last_cnt = CW'(T_LEFT_NS - 1);
         NS_GREEN:        last_cnt = CW'(T_GREEN_NS - 1);
         EW_LEFT:         last_cnt = CW'(T_LEFT_EW - 1);
         EW_GREEN:        last_cnt = CW'(T_GREEN_EW - 1);
         NS_YEL, EW_YEL:  last_cnt = CW'(T_YEL - 1);
         AR1, AR2:        last_cnt = CW'(T_ALLRED - 1);
         PRE_CLR:         last_cnt = CW'(T_YEL - 1);
         default:         last_cnt = '0;
      endcase
   endfunction

   // Where the normal cycle would go at this edge; also what preemption saves.
   always_comb begin
      norm_phase = phase_q;
      norm_cnt   = cnt_q + CW'(1);
      if (cnt_q == last_cnt(phase_q)) begin
         norm_cnt   = '0;
         norm_phase = (phase_q == AR2) ? NS_LEFT : phase_e'(4'(phase_q) + 4'd1);
      end
   end

   always_comb begin
      phase_d       = phase_q;
      cnt_d         = cnt_q;
      hold_d        = hold_q;
      saved_phase_d = saved_phase_q;
      saved_cnt_d   = saved_cnt_q;
      clr_ew_d      = clr_ew_q;
      case (phase_q)
         PRE_CLR: begin
            // emergency is deliberately ignored here; clearance always completes
            if (cnt_q == CW'(T_YEL - 1)) begin
               phase_d = ALLSTOP;
               cnt_d   = '0;
               hold_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ALLSTOP: begin
            if (hold_q >= CW'(EMERG_MIN - 1) && !sig.emergency) begin
               phase_d = saved_phase_q;
               cnt_d   = saved_cnt_q;
            end else if (hold_q != '1) begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: begin
            if (sig.emergency) begin
               saved_phase_d = norm_phase;
               saved_cnt_d   = norm_cnt;
               cnt_d         = '0;
               if (phase_q inside {NS_LEFT, NS_GREEN, EW_LEFT, EW_GREEN}) begin
                  phase_d  = PRE_CLR;
                  clr_ew_d = (phase_q inside {EW_LEFT, EW_GREEN});
               end else begin
                  // already yellow or all-red: no further clearance needed
                  phase_d = ALLSTOP;
                  hold_d  = '0;
               end
            end else begin
               phase_d = norm_phase;
               cnt_d   = norm_cnt;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q       <= NS_LEFT;
         cnt_q         <= '0;
         hold_q        <= '0;
         saved_phase_q <= NS_LEFT;
         saved_cnt_q   <= '0;
         clr_ew_q      <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         cnt_q         <= cnt_d;
         hold_q        <= hold_d;
         saved_phase_q <= saved_phase_d;
         saved_cnt_q   <= saved_cnt_d;
         clr_ew_q      <= clr_ew_d;
      end
   end

   always_comb begin
      sig.out_ns       = 4'b0001;
      sig.out_ew       = 4'b0001;
      sig.phase        = 4'(phase_q);
      sig.emerg_active = 1'b0;
      case (phase_q)
         NS_LEFT:  sig.out_ns = 4'b1001;
         NS_GREEN: sig.out_ns = 4'b0100;
         NS_YEL:   sig.out_ns = 4'b0010;
         EW_LEFT:  sig.out_ew = 4'b1001;
         EW_GREEN: sig.out_ew = 4'b0100;
         EW_YEL:   sig.out_ew = 4'b0010;
         PRE_CLR: begin
            sig.emerg_active = 1'b1;
            if (clr_ew_q) sig.out_ew = 4'b0010;
            else          sig.out_ns = 4'b0010;
         end
         ALLSTOP:  sig.emerg_active = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
module tb_traffic_intersection_ctrl;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   typedef struct {
      logic [3:0] ph;
      logic [3:0] ns;
      logic [3:0] ew;
      logic       ea;
      logic       em;   // emergency value driven after this cycle is checked
   } exp_t;

   exp_t exp_q[$];

   traffic_intersection_ctrl_if tif ();

   traffic_intersection_ctrl dut (
      .clock (clock),
      .reset (reset),
      .sig   (tif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // phase durations at default parameters, in phase-code order 0..7
   int dur [8] = '{5, 10, 3, 2, 5, 10, 3, 2};

   task automatic push(input int ph, input int n, input logic em = 1'b0, input logic ew_side = 1'b0);
      exp_t x;
      x.ph = 4'(ph);
      x.em = em;
      x.ns = 4'b0001;
      x.ew = 4'b0001;
      x.ea = 1'b0;
      case (ph)
         0: x.ns = 4'b1001;
         1: x.ns = 4'b0100;
         2: x.ns = 4'b0010;
         4: x.ew = 4'b1001;
         5: x.ew = 4'b0100;
         6: x.ew = 4'b0010;
         8: begin
            x.ea = 1'b1;
            if (ew_side) x.ew = 4'b0010;
            else         x.ns = 4'b0010;
         end
         9: x.ea = 1'b1;
         default: ;
      endcase
      for (int i = 0; i < n; i++) exp_q.push_back(x);
   endtask

   task automatic push_full_cycle();
      for (int p = 0; p < 8; p++) push(p, dur[p]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tif.emergency = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (tif.phase !== 4'd0) begin
         failures++;
         $display("FAIL reset_phase got=%0d exp=0", tif.phase);
      end
      checks++;
      if (tif.out_ns !== 4'b1001 || tif.out_ew !== 4'b0001) begin
         failures++;
         $display("FAIL reset_lamps got ns=%b ew=%b exp ns=1001 ew=0001", tif.out_ns, tif.out_ew);
      end
      checks++;
      if (tif.emerg_active !== 1'b0) begin
         failures++;
         $display("FAIL reset_emerg_active got=%b exp=0", tif.emerg_active);
      end
      reset = 1'b0;
   endtask

   task automatic test_normal();
      exp_t x;
      int   cyc = 0;
      push_full_cycle();
      push_full_cycle();
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL normal cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic test_preempt_green();
      exp_t x;
      int   cyc = 0;
      push(0, 5);
      push(1, 4);
      push(1, 1, 1'b1);   // NS_GREEN cnt=4
      push(8, 3);
      push(9, 2);
      push(1, 5);         // resumes at cnt=5
      push(2, 3);
      push(3, 2);
      push(4, 5);
      push(5, 10);
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL preempt_green cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic test_preempt_yellow_hold();
      exp_t x;
      int   cyc = 0;
      push(6, 1, 1'b1);   // EW_YEL cnt=0, straight to ALLSTOP
      push(9, 5, 1'b1);   // emergency still held
      push(9, 1, 1'b0);
      push(6, 2);         // resumes at cnt=1
      push(7, 2);
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL preempt_yel_hold cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic test_last_cycle();
      exp_t x;
      int   cyc = 0;
      push(0, 4);
      push(0, 1, 1'b1);   // NS_LEFT last cycle: saves NS_GREEN cnt=0
      push(8, 3);
      push(9, 2);
      push(1, 10);
      push(2, 3);
      push(3, 2);
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL last_cycle cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic test_ew_left_clr_ignore();
      exp_t x;
      int   cyc = 0;
      push(4, 1, 1'b1);         // EW_LEFT cnt=0
      push(8, 2, 1'b1, 1'b1);   // emergency during PRE_CLR has no effect
      push(8, 1, 1'b0, 1'b1);
      push(9, 2);
      push(4, 4);               // resumes at cnt=1
      push(5, 10);
      push(6, 3);
      push(7, 2);
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL ew_left_clr cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid_preempt();
      exp_t x;
      int   cyc = 0;
      push(0, 1, 1'b1);
      push(8, 3, 1'b1);
      push(9, 2, 1'b1);
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL reset_mid_pre cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
      checks++;
      if (tif.phase !== 4'd9) begin
         failures++;
         $display("FAIL reset_mid_pre_allstop got=%0d exp=9", tif.phase);
      end
      tif.emergency = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tif.phase !== 4'd0 || tif.out_ns !== 4'b1001 || tif.out_ew !== 4'b0001 || tif.emerg_active !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got ph=%0d ns=%b ew=%b ea=%b exp ph=0 ns=1001 ew=0001 ea=0",
                  tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active);
      end
      @(negedge clock);
      reset = 1'b0;
      cyc = 0;
      push_full_cycle();
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         checks++;
         if (tif.phase !== x.ph || tif.out_ns !== x.ns || tif.out_ew !== x.ew || tif.emerg_active !== x.ea) begin
            failures++;
            $display("FAIL after_reset cyc=%0d got ph=%0d ns=%b ew=%b ea=%b exp ph=%0d ns=%b ew=%b ea=%b",
                     cyc, tif.phase, tif.out_ns, tif.out_ew, tif.emerg_active, x.ph, x.ns, x.ew, x.ea);
         end
         tif.emergency = x.em;
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic test_random_safety();
      logic ea_exp;
      for (int cyc = 0; cyc < 400; cyc++) begin
         checks++;
         if (tif.out_ns[3:1] != 3'b000 && tif.out_ew[3:1] != 3'b000) begin
            failures++;
            $display("FAIL random_conflict cyc=%0d got ns=%b ew=%b exp at least one red-only", cyc, tif.out_ns, tif.out_ew);
         end
         ea_exp = (tif.phase == 4'd8 || tif.phase == 4'd9);
         checks++;
         if (tif.emerg_active !== ea_exp) begin
            failures++;
            $display("FAIL random_emerg_active cyc=%0d ph=%0d got=%b exp=%b", cyc, tif.phase, tif.emerg_active, ea_exp);
         end
         tif.emergency = ($urandom_range(0, 7) == 0);
         @(negedge clock);
      end
      tif.emergency = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      tif.emergency = 1'b0;
      test_reset();
      test_normal();
      test_preempt_green();
      test_preempt_yellow_hold();
      test_last_cycle();
      test_ew_left_clr_ignore();
      test_reset_mid_preempt();
      test_random_safety();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
